// File: rtl/xor_key_lock_stream_if.sv
// Bundles the key-load port and the locked data stream of xor_key_lock_stream.
// The master side drives the key and plaintext and consumes the locked words.
// The slave side is the lock block itself.
interface xor_key_lock_stream_if #(
   parameter int unsigned DATA_W = 36
);
   logic              key_sdi;
   logic              key_valid;
   logic              key_ready;
   logic              key_clear;
   logic              key_loaded;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output key_sdi, key_valid, key_clear, in_data, in_valid, out_ready,
      input  key_ready, key_loaded, in_ready, out_data, out_valid
   );

   modport slave (
      input  key_sdi, key_valid, key_clear, in_data, in_valid, out_ready,
      output key_ready, key_loaded, in_ready, out_data, out_valid
   );
endinterface

// File: rtl/xor_key_lock_stream.sv
// xor_key_lock_stream: loads a KEY_W-bit key serially (LSB first), then
// XOR/XNOR-locks a DATA_W-bit stream into a 2-entry valid/ready buffer.
// Effective key ek = key ^ KEY_POL; data bit i uses ek[i mod KEY_W].
// Optional feature macro: KEYLOCK_ROTATE_EN -- the mask comes from a rotation
// register loaded with ek on entry to ACTIVE and rotated left by one after
// every accepted input word.
module xor_key_lock_stream #(
   parameter int unsigned       DATA_W  = 36,
   parameter int unsigned       KEY_W   = 32,
   parameter logic [KEY_W-1:0]  KEY_POL = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   xor_key_lock_stream_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(KEY_W);

   localparam logic [0:0] ST_LOAD   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;

   logic              active;
   logic              key_xfer;
   logic              last_bit;
   logic              out_valid_w;
   logic              in_ready_w;
   logic              push;
   logic              pop;
   logic [KEY_W-1:0]  mask_src;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] locked_word;

   assign active      = (state_q == ST_ACTIVE);
   assign key_xfer    = !active && bus.key_valid;
   assign last_bit    = (bit_cnt_q == CNT_W'(KEY_W - 1));
   assign out_valid_w = (count_q != 2'd0);
   assign in_ready_w  = active && !bus.key_clear && (count_q != 2'd2);
   assign push        = bus.in_valid && in_ready_w;
   assign pop         = out_valid_w && bus.out_ready;

   assign bus.key_ready  = !active;
   assign bus.key_loaded = active;
   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = out_valid_w;
   assign bus.out_data   = out_valid_w ? buf0_q : '0;

   // Key repeats across the data word: bit i takes key bit i mod KEY_W.
   for (genvar g = 0; g < DATA_W; g++) begin : g_mask
      assign mask[g] = mask_src[g % KEY_W];
   end

   assign locked_word = bus.in_data ^ mask;

   // FSM and serial key shift; key_clear wins over a same-cycle key transfer.
   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      bit_cnt_d = bit_cnt_q;
      if (bus.key_clear) begin
         state_d   = ST_LOAD;
         key_d     = '0;
         bit_cnt_d = '0;
      end else if (key_xfer) begin
         key_d[bit_cnt_q] = bus.key_sdi;
         if (last_bit) begin
            state_d   = ST_ACTIVE;
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   // Two-entry output buffer; buf0 is always the head, flush overrides push/pop.
   always_comb begin
      count_d = count_q;
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      if (bus.key_clear) begin
         count_d = 2'd0;
      end else begin
         if (pop) begin
            buf0_d = buf1_q;
         end
         if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
               buf0_d = locked_word;
            end else begin
               buf1_d = locked_word;
            end
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef KEYLOCK_ROTATE_EN
   logic [KEY_W-1:0] rk_q, rk_d;

   // Rotation register: seeded from the just-completed key, rotates per accepted word.
   always_comb begin
      rk_d = rk_q;
      if (!active && (state_d == ST_ACTIVE)) begin
         rk_d = key_d ^ KEY_POL;
      end else if (push) begin
         rk_d = {rk_q[KEY_W-2:0], rk_q[KEY_W-1]};
      end
   end

   // Rotation register state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_q <= '0;
      end else begin
         rk_q <= rk_d;
      end
   end

   assign mask_src = rk_q;
`else
   assign mask_src = key_q ^ KEY_POL;
`endif

   // Control and buffer state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_LOAD;
         key_q     <= '0;
         bit_cnt_q <= '0;
         count_q   <= 2'd0;
         buf0_q    <= '0;
         buf1_q    <= '0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         bit_cnt_q <= bit_cnt_d;
         count_q   <= count_d;
         buf0_q    <= buf0_d;
         buf1_q    <= buf1_d;
      end
   end
endmodule

// File: tb/tb_xor_key_lock_stream.sv
// Bench for xor_key_lock_stream: two instances (XOR and XNOR polarity) share
// one stimulus stream; a queue-based reference model predicts every output.
module tb_xor_key_lock_stream;
   localparam int unsigned DW = 36;
   localparam int unsigned KW = 32;
   localparam logic [KW-1:0] POL_A = '0;
   localparam logic [KW-1:0] POL_B = '1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   xor_key_lock_stream_if #(.DATA_W(DW)) ifa ();
   xor_key_lock_stream_if #(.DATA_W(DW)) ifb ();

   xor_key_lock_stream #(.DATA_W(DW), .KEY_W(KW), .KEY_POL(POL_A)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   xor_key_lock_stream #(.DATA_W(DW), .KEY_W(KW), .KEY_POL(POL_B)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model state
   bit          m_active;
   int unsigned m_cnt;
   int unsigned m_nacc;
   logic [KW-1:0] m_key;
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Mask for the n-th accepted word: ek rotated left n times (static when not rotating).
   function automatic logic [DW-1:0] mask_of(input logic [KW-1:0] ek, input int unsigned n);
      logic [DW-1:0] m;
      int unsigned   rot;
`ifdef KEYLOCK_ROTATE_EN
      rot = n % KW;
`else
      rot = 0;
`endif
      for (int unsigned i = 0; i < DW; i++) begin
         m[i] = ek[((i % KW) + KW - rot) % KW];
      end
      return m;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_cnt    = 0;
      m_nacc   = 0;
      m_key    = '0;
      qa.delete();
      qb.delete();
   endtask

   task automatic drive(input bit kv, input bit ksdi, input bit kclr, input bit iv,
                        input logic [DW-1:0] idata, input bit ordy);
      ifa.key_valid = kv;   ifb.key_valid = kv;
      ifa.key_sdi   = ksdi; ifb.key_sdi   = ksdi;
      ifa.key_clear = kclr; ifb.key_clear = kclr;
      ifa.in_valid  = iv;   ifb.in_valid  = iv;
      ifa.in_data   = idata; ifb.in_data  = idata;
      ifa.out_ready = ordy; ifb.out_ready = ordy;
   endtask

   task automatic chk_dut(input string p, input logic kr, input logic kl, input logic ir,
                          input logic ov, input logic [DW-1:0] od, input bit exp_ir,
                          input bit exp_ov, input logic [DW-1:0] exp_od);
      chk({p, "_key_ready"},  kr, !m_active);
      chk({p, "_key_loaded"}, kl, m_active);
      chk({p, "_in_ready"},   ir, exp_ir);
      chk({p, "_out_valid"},  ov, exp_ov);
      chk({p, "_out_data"},   od, exp_od);
   endtask

   // One clock: drive at negedge, check, then advance the model to the next posedge.
   task automatic cycle(input bit kv, input bit ksdi, input bit kclr, input bit iv,
                        input logic [DW-1:0] idata, input bit ordy);
      int unsigned sz;
      bit          do_push;
      @(negedge clk);
      drive(kv, ksdi, kclr, iv, idata, ordy);
      #1;
      sz      = qa.size();
      do_push = m_active && !kclr && iv && (sz < 2);
      chk_dut("a", ifa.key_ready, ifa.key_loaded, ifa.in_ready, ifa.out_valid, ifa.out_data,
              m_active && !kclr && (sz < 2), sz != 0, (sz != 0) ? qa[0] : '0);
      chk_dut("b", ifb.key_ready, ifb.key_loaded, ifb.in_ready, ifb.out_valid, ifb.out_data,
              m_active && !kclr && (qb.size() < 2), qb.size() != 0,
              (qb.size() != 0) ? qb[0] : '0);
      if (kclr) begin
         m_active = 1'b0;
         m_cnt    = 0;
         m_key    = '0;
         qa.delete();
         qb.delete();
      end else begin
         if ((sz != 0) && ordy) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
         if (do_push) begin
            qa.push_back(idata ^ mask_of(m_key ^ POL_A, m_nacc));
            qb.push_back(idata ^ mask_of(m_key ^ POL_B, m_nacc));
            m_nacc++;
         end
         if (!m_active && kv) begin
            m_key[m_cnt] = ksdi;
            m_cnt++;
            if (m_cnt == KW) begin
               m_active = 1'b1;
               m_cnt    = 0;
               m_nacc   = 0;
            end
         end
      end
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, ordy);
   endtask

   task automatic do_reset(input int unsigned ncyc);
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      repeat (ncyc) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic load_key(input logic [KW-1:0] key, input int unsigned maxgap);
      for (int unsigned i = 0; i < KW; i++) begin
         repeat ($urandom_range(0, maxgap)) begin
            cycle(1'b0, 1'($urandom), 1'b0, 1'($urandom), DW'({$urandom, $urandom}), 1'($urandom));
         end
         cycle(1'b1, key[i], 1'b0, 1'b0, '0, 1'b0);
      end
   endtask

   logic [DW-1:0] t6_exp[3];

   initial begin
      model_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

      // T1: reset values
      do_reset(2);
      idle(1'b0);
      chk("T1_key_ready", ifa.key_ready, 1'b1);
      chk("T1_in_ready",  ifa.in_ready,  1'b0);
      chk("T1_out_valid", ifa.out_valid, 1'b0);
      chk("T1_out_data",  ifa.out_data,  '0);

      // T2: load key with gaps, lock a zero word
      load_key(32'hA5A5_0F0F, 3);
      idle(1'b0);
      chk("T2_key_loaded", ifa.key_loaded, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      idle(1'b0);
      chk("T2_out_a", ifa.out_data, 36'hF_A5A5_0F0F);
      chk("T2_out_b", ifb.out_data, 36'h0_5A5A_F0F0);
      idle(1'b1);

      // T3: backpressure, third word stalls, then drain in order
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 36'h1_1111_1111, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 36'h2_2222_2222, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 36'h3_3333_3333, 1'b0);
      chk("T3_full_in_ready", ifa.in_ready, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 36'h3_3333_3333, 1'b1);
      repeat (4) idle(1'b1);
      chk("T3_drained", ifa.out_valid, 1'b0);

      // T4: key_clear with two words buffered, then reload same key
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 36'h0_DEAD_BEEF, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 36'h9_1234_5678, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 36'h0_0000_0000, 1'b0);
      idle(1'b0);
      chk("T4_flushed", ifa.out_valid, 1'b0);
      chk("T4_unloaded", ifa.key_loaded, 1'b0);
      load_key(32'hA5A5_0F0F, 2);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      idle(1'b0);
      chk("T4_reload_out", ifa.out_data, 36'hF_A5A5_0F0F);
      idle(1'b1);

      // T5: reset after 10 key bits, full reload of key 0
      do_reset(2);
      for (int unsigned i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      do_reset(2);
      idle(1'b0);
      chk("T5_partial_lost", ifa.key_loaded, 1'b0);
      load_key('0, 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      idle(1'b0);
      chk("T5_xnor_out", ifb.out_data, 36'hF_FFFF_FFFF);
      chk("T5_xor_out",  ifa.out_data, '0);
      idle(1'b1);

      // T6: key 1, three zero words
`ifdef KEYLOCK_ROTATE_EN
      t6_exp[0] = 36'h1_0000_0001;
      t6_exp[1] = 36'h2_0000_0002;
      t6_exp[2] = 36'h4_0000_0004;
`else
      t6_exp[0] = 36'h1_0000_0001;
      t6_exp[1] = 36'h1_0000_0001;
      t6_exp[2] = 36'h1_0000_0001;
`endif
      do_reset(2);
      load_key(32'h1, 0);
      for (int unsigned k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
         idle(1'b0);
         chk($sformatf("T6_word%0d", k), ifa.out_data, t6_exp[k]);
         idle(1'b1);
      end

      // Randomized traffic with occasional key_clear and reloads
      for (int unsigned c = 0; c < 1500; c++) begin
         cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 79) == 0),
               1'($urandom), DW'({$urandom, $urandom}), ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
